// File: rtl/avr_mon_pkg.sv
// Shared definitions for the AVR pin monitor.
// Each event is packed as {time, pins, changed}, with changed in the LSBs.
// The helpers below give the packed width and the field offsets for a given
// pin count and timestamp width.
package avr_mon_pkg;

   localparam int DROP_W  = 16;
   localparam int CHG_LSB = 0;

   function automatic int ev_w(input int npins, input int ts_w);
      return ts_w + 2 * npins;
   endfunction

   function automatic int pins_lsb(input int npins);
      return npins;
   endfunction

   function automatic int time_lsb(input int npins);
      return 2 * npins;
   endfunction

endpackage

// File: rtl/avr_mon_fifo.sv
// Synchronous first-word-fall-through FIFO that holds the queued pin events.
// rdata always shows the head entry, and it reads as zero when the FIFO is empty.
// A push and a pop in the same cycle are both accepted, even when the FIFO is full.
// In that case the level does not change.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   push, wdata  write request and its data (ignored when full without pop)
//   pop          consume head (ignored when empty)
//   rdata        head entry
//   full, empty  occupancy flags
//   level        exact occupancy, 0..DEPTH
module avr_mon_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    cnt;
   logic             wr_en;
   logic             rd_en;

   assign full  = (cnt == LW'(DEPTH));
   assign empty = (cnt == '0);
   assign level = cnt;

   // When the FIFO is full, a pop frees the head slot in this same cycle.
   // That slot is the one wr_ptr points at, so the push can be written there.
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + LW'(wr_en) - LW'(rd_en);
      end
   end

   assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/avr_pin_monitor.sv
// Multi-channel edge-event recorder for AVR co-simulation benches.
// The monitor synchronises and deglitches NPINS pin levels.
// Each qualifying edge on the filtered levels is timestamped and queued in a FIFO.
// The FIFO is drained over a valid/ready interface.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pins                raw pin levels
//   rise_en, fall_en    per-channel edge qualification
//   ev_valid, ev_ready  head handshake
//   ev_time, ev_pins,   head event: commit timestamp, filtered pins after the
//   ev_changed            event, channels whose qualifying edge caused it
//   ev_level            FIFO occupancy
//   overflow, drop_cnt  sticky drop flag and saturating drop count
//   clear_ovf           clears overflow/drop_cnt (a same-cycle drop wins)
module avr_pin_monitor
   import avr_mon_pkg::*;
#(
   parameter int NPINS       = 8,
   parameter int DEPTH       = 16,
   parameter int TS_W        = 32,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NPINS-1:0]            pins,
   input  logic [NPINS-1:0]            rise_en,
   input  logic [NPINS-1:0]            fall_en,
   output logic                        ev_valid,
   input  logic                        ev_ready,
   output logic [TS_W-1:0]             ev_time,
   output logic [NPINS-1:0]            ev_pins,
   output logic [NPINS-1:0]            ev_changed,
   output logic [$clog2(DEPTH+1)-1:0]  ev_level,
   output logic                        overflow,
   output logic [DROP_W-1:0]           drop_cnt,
   input  logic                        clear_ovf
);

   localparam int EVW      = ev_w(NPINS, TS_W);
   localparam int PINS_LSB = pins_lsb(NPINS);
   localparam int TIME_LSB = time_lsb(NPINS);
   localparam int CW       = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

   logic [TS_W-1:0]  ts_q;
   logic [NPINS-1:0] sync_q [SYNC_STAGES];
   logic [NPINS-1:0] synced;
   logic [NPINS-1:0] filt_q;
   logic [NPINS-1:0] filt_next;
   logic [CW-1:0]    cnt_q [NPINS];
   logic [NPINS-1:0] rise;
   logic [NPINS-1:0] fall;
   logic [NPINS-1:0] changed;
   logic             push_q;
   logic [EVW-1:0]   push_data_q;
   logic [EVW-1:0]   head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             drop;

   always_ff @(posedge clk) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // A channel commits only after it has differed for FILTER consecutive cycles.
   // On the commit edge the synced value is still different, so the change is
   // seen for FILTER+1 samples in total before it is accepted.
   always_comb begin
      filt_next = filt_q;
      for (int i = 0; i < NPINS; i++) begin
         if (synced[i] != filt_q[i] && cnt_q[i] == CW'(FILTER)) begin
            filt_next[i] = synced[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= '0;
         for (int i = 0; i < NPINS; i++) cnt_q[i] <= '0;
      end else begin
         filt_q <= filt_next;
         for (int i = 0; i < NPINS; i++) begin
            if (synced[i] == filt_q[i] || cnt_q[i] == CW'(FILTER)) cnt_q[i] <= '0;
            else                                                   cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   assign rise    = filt_next & ~filt_q;
   assign fall    = ~filt_next & filt_q;
   assign changed = (rise & rise_en) | (fall & fall_en);

   // Register the event once before it is pushed into the FIFO.
   // The stored timestamp is the ts value on the commit cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         push_q      <= 1'b0;
         push_data_q <= '0;
      end else begin
         push_q      <= |changed;
         push_data_q <= {ts_q, filt_next, changed};
      end
   end

   assign pop  = ev_valid & ev_ready;
   assign drop = push_q & fifo_full & ~pop;

   avr_mon_fifo #(
      .WIDTH (EVW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .wdata (push_data_q),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (ev_level)
   );

   assign ev_valid   = ~fifo_empty;
   assign ev_time    = head[TIME_LSB +: TS_W];
   assign ev_pins    = head[PINS_LSB +: NPINS];
   assign ev_changed = head[CHG_LSB  +: NPINS];

   // If a clear and a drop happen in the same cycle, the drop is recorded.
   // The drop then counts as the first one after the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_ovf)          drop_cnt <= DROP_W'(1);
         else if (&drop_cnt)     drop_cnt <= drop_cnt;
         else                    drop_cnt <= drop_cnt + 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_avr_pin_monitor.sv
module tb_avr_pin_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pins;
   logic [7:0]  rise_en;
   logic [7:0]  fall_en;
   logic        ev_valid;
   logic        ev_ready;
   logic [31:0] ev_time;
   logic [7:0]  ev_pins;
   logic [7:0]  ev_changed;
   logic [2:0]  ev_level;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic        clear_ovf;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int t0, t2, t3;

   always #5 clk = ~clk;

   avr_pin_monitor #(
      .NPINS       (8),
      .DEPTH       (4),
      .TS_W        (32),
      .SYNC_STAGES (2),
      .FILTER      (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pins       (pins),
      .rise_en    (rise_en),
      .fall_en    (fall_en),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_time    (ev_time),
      .ev_pins    (ev_pins),
      .ev_changed (ev_changed),
      .ev_level   (ev_level),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .clear_ovf  (clear_ovf)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_one();
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pins = 8'h00; rise_en = 8'hFF; fall_en = 8'hFF;
      ev_ready = 1'b0; clear_ovf = 1'b0;
      tick(3);
      rst = 1'b0;
      cyc = 0;

      // reset state
      chk("rst_valid",    64'(ev_valid), 64'd0);
      chk("rst_level",    64'(ev_level), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drop",     64'(drop_cnt), 64'd0);
      chk("rst_time",     64'(ev_time),  64'd0);

      // 1: single rising edge, latency
      tick(10);
      pins = 8'h01;
      tick(5);
      chk("t1_valid_early", 64'(ev_valid), 64'd0);
      tick(1);
      chk("t1_valid",   64'(ev_valid),   64'd1);
      chk("t1_time",    64'(ev_time),    64'd14);
      chk("t1_pins",    64'(ev_pins),    64'h01);
      chk("t1_changed", 64'(ev_changed), 64'h01);
      chk("t1_level",   64'(ev_level),   64'd1);
      pop_one();
      chk("t1_popped",  64'(ev_level),   64'd0);

      // 2: glitch filter
      pins = 8'h09;
      tick(2);
      pins = 8'h01;
      tick(10);
      chk("t2_glitch_level", 64'(ev_level), 64'd0);
      t0 = cyc;
      pins = 8'h09;
      tick(3);
      pins = 8'h01;
      tick(10);
      chk("t2_level",     64'(ev_level),   64'd2);
      chk("t2_rise_time", 64'(ev_time),    64'(t0 + 4));
      chk("t2_rise_pins", 64'(ev_pins),    64'h09);
      chk("t2_rise_chg",  64'(ev_changed), 64'h08);
      tick(1);
      chk("t2_head_stable", 64'(ev_time),  64'(t0 + 4));
      pop_one();
      chk("t2_fall_time", 64'(ev_time),    64'(t0 + 7));
      chk("t2_fall_pins", 64'(ev_pins),    64'h01);
      chk("t2_fall_chg",  64'(ev_changed), 64'h08);
      pop_one();
      chk("t2_empty",     64'(ev_valid),   64'd0);

      // 3: non-qualifying fall, then shared entry for simultaneous edges
      fall_en = 8'h00;
      pins = 8'h00;
      tick(10);
      chk("t3_nonqual_level", 64'(ev_level), 64'd0);
      rise_en = 8'h80;
      t0 = cyc;
      pins = 8'h81;
      tick(6);
      chk("t3_level",   64'(ev_level),   64'd1);
      chk("t3_time",    64'(ev_time),    64'(t0 + 4));
      chk("t3_changed", 64'(ev_changed), 64'h80);
      chk("t3_pins",    64'(ev_pins),    64'h81);
      pop_one();
      rise_en = 8'hFF;
      fall_en = 8'hFF;
      tick(10);
      chk("t3_quiet", 64'(ev_level), 64'd0);

      // 4: overflow with six queued edges
      t2 = cyc;
      for (int k = 0; k < 6; k++) begin
         pins = pins ^ 8'h02;
         tick(5);
      end
      tick(3);
      chk("t4_level",    64'(ev_level), 64'd4);
      chk("t4_overflow", 64'(overflow), 64'd1);
      chk("t4_drop",     64'(drop_cnt), 64'd2);
      chk("t4_head_time", 64'(ev_time), 64'(t2 + 4));
      chk("t4_head_pins", 64'(ev_pins), 64'h83);
      clear_ovf = 1'b1;
      tick(1);
      clear_ovf = 1'b0;
      chk("t4_clr_ovf",  64'(overflow), 64'd0);
      chk("t4_clr_drop", 64'(drop_cnt), 64'd0);

      // 5: push into full FIFO with simultaneous pop
      t3 = cyc;
      pins = pins ^ 8'h02;
      tick(5);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
      chk("t5_level",    64'(ev_level), 64'd4);
      chk("t5_overflow", 64'(overflow), 64'd0);
      chk("t5_drop",     64'(drop_cnt), 64'd0);
      chk("t5_q0_time", 64'(ev_time), 64'(t2 + 9));
      chk("t5_q0_pins", 64'(ev_pins), 64'h81);
      pop_one();
      chk("t5_q1_time", 64'(ev_time), 64'(t2 + 14));
      chk("t5_q1_pins", 64'(ev_pins), 64'h83);
      pop_one();
      chk("t5_q2_time", 64'(ev_time), 64'(t2 + 19));
      chk("t5_q2_pins", 64'(ev_pins), 64'h81);
      pop_one();
      chk("t5_q3_time", 64'(ev_time), 64'(t3 + 4));
      chk("t5_q3_pins", 64'(ev_pins), 64'h83);
      pop_one();
      chk("t5_empty",   64'(ev_level), 64'd0);

      // 6: reset mid-operation
      for (int k = 0; k < 3; k++) begin
         pins = pins ^ 8'h02;
         tick(5);
      end
      tick(3);
      chk("t6_pre_level", 64'(ev_level), 64'd3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      cyc = 0;
      chk("t6_valid",    64'(ev_valid), 64'd0);
      chk("t6_level",    64'(ev_level), 64'd0);
      chk("t6_overflow", 64'(overflow), 64'd0);
      tick(5);
      chk("t6_valid_early", 64'(ev_valid), 64'd0);
      tick(1);
      chk("t6_rise_valid", 64'(ev_valid),   64'd1);
      chk("t6_rise_time",  64'(ev_time),    64'd4);
      chk("t6_rise_pins",  64'(ev_pins),    64'h81);
      chk("t6_rise_chg",   64'(ev_changed), 64'h81);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
